// File: rtl/prime_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : prime_arbiter
// Description : Round-robin front end sharing one prime-test core among NREQ
//               requesters, with a one-job-in-flight watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module prime_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] n_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic              rsp_prime,
    output logic              rsp_err,
    output logic              busy,
    output logic              core_start,
    output logic [W-1:0]      core_n,
    output logic              core_abort,
    input  logic              core_done,
    input  logic              core_prime
);

    localparam int                c_id_w    = $clog2(NREQ);
    localparam int                c_wd_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state,       w_state_nxt;
    logic [c_id_w-1:0] r_ptr,         w_ptr_nxt;
    logic [c_id_w-1:0] r_owner,       w_owner_nxt;
    logic [c_wd_w-1:0] r_wd,          w_wd_nxt;
    logic [W-1:0]      r_core_n,      w_core_n_nxt;
    logic [NREQ-1:0]   r_gnt,         w_gnt_nxt;
    logic [NREQ-1:0]   r_rsp_valid,   w_rsp_valid_nxt;
    logic              r_rsp_prime,   w_rsp_prime_nxt;
    logic              r_rsp_err,     w_rsp_err_nxt;
    logic              r_busy,        w_busy_nxt;
    logic              r_core_start,  w_core_start_nxt;
    logic              r_core_abort,  w_core_abort_nxt;

    logic              w_found;
    logic [c_id_w-1:0] w_sel;
    logic [NREQ-1:0]   w_sel_oh;
    logic [W-1:0]      w_sel_n;
    logic [NREQ-1:0]   w_own_oh;
    int                w_dist;
    int                w_best;

    // Pick the requester with the smallest wrapped distance from the pointer.
    always_comb begin
        w_found  = 1'b0;
        w_sel    = '0;
        w_sel_oh = '0;
        w_best   = NREQ;
        w_dist   = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = i - int'(r_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NREQ;
            end
            if (req[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_found  = 1'b1;
                w_sel    = c_id_w'(i);
                w_sel_oh = '0;
                w_sel_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_n  = '0;
        w_own_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == c_id_w'(i)) begin
                w_sel_n = n_in[i*W +: W];
            end
            w_own_oh[i] = (r_owner == c_id_w'(i));
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_owner_nxt      = r_owner;
        w_wd_nxt         = r_wd;
        w_core_n_nxt     = r_core_n;
        w_gnt_nxt        = '0;
        w_rsp_valid_nxt  = '0;
        w_rsp_prime_nxt  = 1'b0;
        w_rsp_err_nxt    = 1'b0;
        w_core_start_nxt = 1'b0;
        w_core_abort_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt      = S_ISSUE;
                    w_owner_nxt      = w_sel;
                    w_core_n_nxt     = w_sel_n;
                    w_ptr_nxt        = (w_sel == c_id_w'(NREQ - 1)) ? '0 : w_sel + 1'b1;
                    w_gnt_nxt        = w_sel_oh;
                    w_core_start_nxt = (w_sel_n >= W'(2));
                end
            end
            S_ISSUE: begin
                if (r_core_n >= W'(2)) begin
                    w_state_nxt = S_WAIT;
                    w_wd_nxt    = '0;
                end else begin
                    // 0 and 1 are answered locally; the core never sees them.
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = w_own_oh;
                end
            end
            S_WAIT: begin
                w_wd_nxt = r_wd + 1'b1;
                if (core_done) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = w_own_oh;
                    w_rsp_prime_nxt = core_prime;
                end else if (r_wd == c_wd_last) begin
                    w_state_nxt      = S_RESP;
                    w_rsp_valid_nxt  = w_own_oh;
                    w_rsp_err_nxt    = 1'b1;
                    w_core_abort_nxt = 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_wd         <= '0;
            r_core_n     <= '0;
            r_gnt        <= '0;
            r_rsp_valid  <= '0;
            r_rsp_prime  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
            r_core_start <= 1'b0;
            r_core_abort <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_owner      <= w_owner_nxt;
            r_wd         <= w_wd_nxt;
            r_core_n     <= w_core_n_nxt;
            r_gnt        <= w_gnt_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_prime  <= w_rsp_prime_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
            r_busy       <= w_busy_nxt;
            r_core_start <= w_core_start_nxt;
            r_core_abort <= w_core_abort_nxt;
        end
    end

    assign gnt        = r_gnt;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_prime  = r_rsp_prime;
    assign rsp_err    = r_rsp_err;
    assign busy       = r_busy;
    assign core_start = r_core_start;
    assign core_n     = r_core_n;
    assign core_abort = r_core_abort;

endmodule
`default_nettype wire

// File: tb/tb_prime_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prime_arbiter
// Description : Directed self-checking bench for prime_arbiter with a
//               timestamp-based job model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prime_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 16;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] n_in;
    logic              core_done;
    logic              core_prime;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic              rsp_prime;
    logic              rsp_err;
    logic              busy;
    logic              core_start;
    logic [W-1:0]      core_n;
    logic              core_abort;

    always #5 clk = ~clk;

    prime_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .n_in       (n_in),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_prime  (rsp_prime),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .core_start (core_start),
        .core_n     (core_n),
        .core_abort (core_abort),
        .core_done  (core_done),
        .core_prime (core_prime)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (((int'(v) >> i) & 1) == 1) r = i;
        end
        return r;
    endfunction

    // Job model: one job at a time, described by the cycle it was accepted
    // and the cycle its response is due.
    int ecnt     = 0;
    bit m_act    = 1'b0;
    int m_own    = 0;
    int m_n      = 0;
    int m_acc    = 0;
    int m_resp   = -1;
    bit m_prime  = 1'b0;
    bit m_err    = 1'b0;
    bit m_abort  = 1'b0;
    int m_ptr    = 0;
    int m_core_n = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act    = 1'b0;
            m_ptr    = 0;
            m_core_n = 0;
            m_resp   = -1;
        end else begin
            int pick;
            int rq;
            int k;
            ecnt++;
            if (m_act && m_resp >= 0) begin
                if (ecnt == m_resp + 1) m_act = 1'b0;
            end else if (m_act) begin
                k = ecnt - m_acc - 1;
                if (k >= 1) begin
                    if (core_done) begin
                        m_resp = ecnt; m_prime = core_prime; m_err = 1'b0; m_abort = 1'b0;
                    end else if (k == TIMEOUT) begin
                        m_resp = ecnt; m_prime = 1'b0; m_err = 1'b1; m_abort = 1'b1;
                    end
                end
            end else begin
                rq   = int'(req);
                pick = -1;
                for (int i = m_ptr; i < NREQ; i++) if (pick < 0 && ((rq >> i) & 1) == 1) pick = i;
                for (int i = 0; i < m_ptr; i++)    if (pick < 0 && ((rq >> i) & 1) == 1) pick = i;
                if (pick >= 0) begin
                    m_act    = 1'b1;
                    m_own    = pick;
                    m_n      = int'((n_in >> (pick * W)) & 32'hFF);
                    m_core_n = m_n;
                    m_acc    = ecnt;
                    m_ptr    = (pick + 1) % NREQ;
                    m_resp   = -1;
                    if (m_n < 2) begin
                        m_resp = ecnt + 1; m_prime = 1'b0; m_err = 1'b0; m_abort = 1'b0;
                    end
                end
            end
        end
    end

    // Observation log and stimulus state
    int              gnt_q[$];
    int              rsp_q[$];
    int              start_cnt = 0;
    int              abort_cnt = 0;
    int              rsp_cnt   = 0;
    logic [NREQ-1:0] last_gv   = '0;
    logic [NREQ-1:0] last_rv   = '0;
    logic            last_rp   = 1'b0;
    logic            last_re   = 1'b0;
    int              last_gcyc = 0;
    int              last_rcyc = 0;
    int              last_dcyc = 0;
    int              last_acyc = 0;
    int              cfg_delay = 0;
    logic            cfg_prime = 1'b0;
    int              cd        = 0;

    task automatic clr();
        gnt_q.delete();
        rsp_q.delete();
        start_cnt = 0;
        abort_cnt = 0;
    endtask

    task automatic step();
        int eg;
        int er;
        bit es;
        @(negedge clk);
        eg = (m_act && ecnt == m_acc)  ? (1 << m_own) : 0;
        er = (m_act && ecnt == m_resp) ? (1 << m_own) : 0;
        es = m_act && (ecnt == m_acc) && (m_n >= 2);
        chk("cyc_gnt",        32'(gnt),        32'(eg));
        chk("cyc_rsp_valid",  32'(rsp_valid),  32'(er));
        chk("cyc_core_start", 32'(core_start), 32'(es));
        chk("cyc_core_abort", 32'(core_abort), 32'((er != 0) && m_abort));
        chk("cyc_busy",       32'(busy),       32'(m_act));
        if (er != 0) begin
            chk("cyc_rsp_prime", 32'(rsp_prime), 32'(m_prime));
            chk("cyc_rsp_err",   32'(rsp_err),   32'(m_err));
        end
        if (m_act) chk("cyc_core_n", 32'(core_n), 32'(m_core_n));

        if (gnt != '0) begin gnt_q.push_back(oh2i(gnt)); last_gv = gnt; last_gcyc = ecnt; end
        if (core_start) start_cnt++;
        if (core_abort) begin abort_cnt++; last_acyc = ecnt; end
        if (rsp_valid != '0) begin
            rsp_cnt++;
            rsp_q.push_back(oh2i(rsp_valid));
            last_rv = rsp_valid; last_rp = rsp_prime; last_re = rsp_err; last_rcyc = ecnt;
        end

        req       = req & ~gnt;
        core_done = 1'b0;
        if (!rst_n) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin core_done = 1'b1; core_prime = cfg_prime; last_dcyc = ecnt; end
            end
            if (core_start && cfg_delay > 0) cd = cfg_delay;
        end
    endtask

    task automatic wait_rsp(input string name, input int budget);
        int c0 = rsp_cnt;
        int k  = 0;
        while (rsp_cnt == c0 && k < budget) begin step(); k++; end
        chk({name, "_rsp_seen"}, 32'(rsp_cnt > c0), 32'd1);
    endtask

    task automatic wait_gnt(input string name, input int budget);
        int c0 = gnt_q.size();
        int k  = 0;
        while (gnt_q.size() == c0 && k < budget) begin step(); k++; end
        chk({name, "_gnt_seen"}, 32'(gnt_q.size() > c0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before t=200000");
        $fatal(1, "global timeout");
    end

    initial begin
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        req = '0; n_in = '0; core_done = 1'b0; core_prime = 1'b0;

        repeat (3) step();
        chk("reset_gnt",       32'(gnt),       32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_core_n",    32'(core_n),    32'd0);
        rst_n = 1'b1;
        step();

        // Round-robin from ptr=0; requester 0 re-requests after its first job.
        clr(); cfg_delay = 3; cfg_prime = 1'b0;
        n_in = {8'd9, 8'd9, 8'd9, 8'd9};
        req  = 4'b1111;
        wait_rsp("rr_first", 40);
        req[0] = 1'b1;
        repeat (4) wait_rsp("rr", 40);
        chk("rr_num_gnt", 32'(gnt_q.size()), 32'd5);
        for (int k = 0; k < 5 && k < gnt_q.size(); k++) chk($sformatf("rr_gnt_order%0d", k), 32'(gnt_q[k]), 32'(exp_rr[k]));
        for (int k = 0; k < 5 && k < rsp_q.size(); k++) chk($sformatf("rr_rsp_order%0d", k), 32'(rsp_q[k]), 32'(exp_rr[k]));
        chk("rr_starts", 32'(start_cnt), 32'd5);
        chk("rr_last_prime", 32'(last_rp), 32'd0);
        step();

        // Single job, done five cycles after start.
        clr(); cfg_delay = 5; cfg_prime = 1'b1;
        n_in[0*W +: W] = 8'd7; req[0] = 1'b1;
        wait_rsp("single", 40);
        chk("single_gnt",     32'(last_gv),             32'h1);
        chk("single_num_gnt", 32'(gnt_q.size()),        32'd1);
        chk("single_starts",  32'(start_cnt),           32'd1);
        chk("single_rv",      32'(last_rv),             32'h1);
        chk("single_prime",   32'(last_rp),             32'd1);
        chk("single_err",     32'(last_re),             32'd0);
        chk("single_done_lat", 32'(last_rcyc - last_dcyc), 32'd1);
        chk("single_job_lat", 32'(last_rcyc - last_gcyc), 32'd6);
        step(); step();

        // Bypass with n=0 then n=1 on requester 2.
        clr(); cfg_delay = 3;
        n_in[2*W +: W] = 8'd0; req[2] = 1'b1;
        wait_rsp("byp0", 10);
        chk("byp0_rv",    32'(last_rv),               32'h4);
        chk("byp0_prime", 32'(last_rp),               32'd0);
        chk("byp0_lat",   32'(last_rcyc - last_gcyc), 32'd1);
        n_in[2*W +: W] = 8'd1; req[2] = 1'b1;
        wait_rsp("byp1", 10);
        chk("byp1_rv",    32'(last_rv),               32'h4);
        chk("byp1_prime", 32'(last_rp),               32'd0);
        chk("byp1_err",   32'(last_re),               32'd0);
        chk("byp1_lat",   32'(last_rcyc - last_gcyc), 32'd1);
        chk("byp_starts", 32'(start_cnt),             32'd0);

        // Timeout: the core never answers.
        clr(); cfg_delay = 0;
        n_in[1*W +: W] = 8'd11; req[1] = 1'b1;
        wait_rsp("to", 40);
        chk("to_aborts",  32'(abort_cnt),             32'd1);
        chk("to_err",     32'(last_re),               32'd1);
        chk("to_prime",   32'(last_rp),               32'd0);
        chk("to_rv",      32'(last_rv),               32'h2);
        chk("to_lat",     32'(last_rcyc - last_gcyc), 32'd17);
        chk("to_abort_at_rsp", 32'(last_acyc),        32'(last_rcyc));

        // Done on the 16th WAIT cycle beats the watchdog.
        clr(); cfg_delay = 16; cfg_prime = 1'b1;
        req[1] = 1'b1;
        wait_rsp("to_done", 40);
        chk("to_done_aborts", 32'(abort_cnt),             32'd0);
        chk("to_done_err",    32'(last_re),               32'd0);
        chk("to_done_prime",  32'(last_rp),               32'd1);
        chk("to_done_lat",    32'(last_rcyc - last_gcyc), 32'd17);
        step(); step();

        // Stray done in IDLE and in ISSUE.
        clr(); cfg_delay = 4; cfg_prime = 1'b1;
        core_done = 1'b1; core_prime = 1'b0;
        step();
        chk("stray_idle_busy", 32'(busy), 32'd0);
        n_in[3*W +: W] = 8'd13; req[3] = 1'b1;
        wait_gnt("stray", 10);
        core_done = 1'b1; core_prime = 1'b0;
        wait_rsp("stray", 20);
        chk("stray_lat",   32'(last_rcyc - last_gcyc), 32'd5);
        chk("stray_prime", 32'(last_rp),              32'd1);
        chk("stray_rv",    32'(last_rv),              32'h8);
        step(); step();

        // Reset in the middle of WAIT, with the pointer left at 1.
        clr(); cfg_delay = 0;
        n_in[0*W +: W] = 8'd20; req[0] = 1'b1;
        wait_gnt("rst_job", 10);
        step(); step(); step();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt",        32'(gnt),        32'd0);
        chk("arst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("arst_rsp_prime",  32'(rsp_prime),  32'd0);
        chk("arst_rsp_err",    32'(rsp_err),    32'd0);
        chk("arst_busy",       32'(busy),       32'd0);
        chk("arst_core_start", 32'(core_start), 32'd0);
        chk("arst_core_abort", 32'(core_abort), 32'd0);
        chk("arst_core_n",     32'(core_n),     32'd0);
        step();
        clr(); cfg_delay = 2; cfg_prime = 1'b0;
        n_in[0*W +: W] = 8'd5; n_in[1*W +: W] = 8'd6;
        req   = 4'b0011;
        rst_n = 1'b1;
        wait_rsp("post_rst_a", 20);
        wait_rsp("post_rst_b", 20);
        chk("post_rst_num_gnt", 32'(gnt_q.size()), 32'd2);
        if (gnt_q.size() >= 2) begin
            chk("post_rst_first", 32'(gnt_q[0]), 32'd0);
            chk("post_rst_second", 32'(gnt_q[1]), 32'd1);
        end
        chk("post_rst_aborts", 32'(abort_cnt), 32'd0);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
